unidade_busca: RTL and testbench
================================

# unidade_busca

- Instruction fetch stage: owns the program counter and drives `Endereco` into the instruction memory.
- The instruction memory updates its `Instrucao` output on the falling clock edge. This block captures that word on the next rising edge into an output register.
- It presents the word to the decoder with a valid/ready handshake, and handles stalls, taken branches/jumps and a halt word.

## Interface
Parameters:
- `LARGURA`, default 8: address and instruction width. The memory holds 2^LARGURA words.
- `PC_INICIAL`, default 8'h00: PC value loaded on reset.
- `PALAVRA_PARADA`, default 8'hFF: instruction encoding that halts fetch.

Ports:
- `Clock`  in  1: single clock, rising-edge logic. Memory reads happen on the falling edge.
- `Reset`  in  1: synchronous, active-high.
- `Endereco`  out  LARGURA: address to the instruction memory. Equals the PC register.
- `Instrucao`  in  LARGURA: word from the instruction memory, valid at the rising edge that follows the falling edge.
- `Desvio`  in  1: redirect request (taken branch/jump), one-cycle pulse.
- `AlvoDesvio`  in  LARGURA: redirect target, sampled when `Desvio`=1.
- `Pronto`  in  1: decoder can accept this cycle.
- `Valida`  out  1: `InstrucaoSaida`/`PcSaida` hold a valid word.
- `InstrucaoSaida`  out  LARGURA: fetched instruction.
- `PcSaida`  out  LARGURA: address the instruction was fetched from.
- `Parado`  out  1: fetch halted (state PARADO).
- `Volta`  out  1: one-cycle pulse when the PC wraps from 2^LARGURA-1 to 0.

## Operation
- **States:** BUSCA and PARADO.
- **Reset:**
  - PC=`PC_INICIAL`; state=BUSCA.
  - `Valida`=0, `InstrucaoSaida`=0, `PcSaida`=0, `Parado`=0, `Volta`=0.
  - Applies regardless of state or pending handshake. Reset mid-operation discards the output register.
- **Transfer:** `Valida`&&`Pronto` at a rising edge.
- **Capture condition:** state=BUSCA, `Desvio`=0, and (`Valida`=0 or transfer).
- **On capture:**
  - `InstrucaoSaida`<=`Instrucao`, `PcSaida`<=PC, `Valida`<=1.
  - PC<=PC+1, modulo 2^LARGURA. `Volta`=1 in the cycle after the PC wraps to 0.
- **If the captured word equals `PALAVRA_PARADA`:**
  - The word is still delivered.
  - State<=PARADO and the PC is not incremented.
- **Stall** (`Valida`=1, `Pronto`=0, no `Desvio`):
  - PC, output register and state hold.
  - The memory keeps re-reading the same address.
- **Transfer with no capture** (PARADO): `Valida`<=0.
- **`Desvio`=1** (priority over stall, capture and halt):
  - PC<=`AlvoDesvio`, `Valida`<=0, state<=BUSCA.
  - The word on `Instrucao` in that cycle is discarded.
  - A pending un-transferred output is also discarded.
- **PARADO:**
  - PC and `Endereco` frozen; `Parado`=1.
  - Exit only through `Desvio` (to BUSCA) or `Reset`.
- **Simultaneous `Desvio` and transfer:** the decoder still takes the current word, then the redirect applies.

## Timing
- Address to data:
  - PC updates at rising edge N.
  - The memory outputs mem[PC] at the falling edge of cycle N.
  - Captured at rising edge N+1 (1-cycle latency).
- After reset deasserts: first `Valida`=1 at the first rising edge with `Reset`=0, with `InstrucaoSaida`=mem[`PC_INICIAL`].
- Steady state with `Pronto`=1: one instruction per cycle. `PcSaida` increments by 1 each cycle.
- Redirect: `Desvio` at edge N gives `Valida`=0 after N and mem[`AlvoDesvio`] valid after edge N+1, a 1-cycle bubble.
- Halt: the halt word is valid after edge N. `Parado`=1 after edge N. `Valida` drops at the edge after it transfers.
- All outputs are registered. There is no combinational path from `Pronto`/`Desvio` to any output.

## Structure
- **Shared package:**
  - State encoding (BUSCA, PARADO).
  - `LARGURA` default.
  - `PALAVRA_PARADA` constant; the decoder uses the same halt word.
- **Sub-module `contador_programa`:** the PC register with controls load (`AlvoDesvio`), increment, hold and reset-to-`PC_INICIAL`. It also produces `Volta`.
- **Top level:** state register, capture/output register and handshake logic.

## Test plan
- Memory preloaded mem[0..3]=01,02,03,04; `Pronto`=1; release reset → `PcSaida`/`InstrucaoSaida` = 00/01, 01/02, 02/03, 03/04 on consecutive cycles. `Valida`=1 from the first edge.
- `Pronto`=0 for 3 cycles while `InstrucaoSaida`=02 at `PcSaida`=01 → outputs and `Endereco`=02 hold. `Pronto`=1 → 03 at PC 02 on the next cycle, with no word lost or duplicated.
- `Desvio`=1, `AlvoDesvio`=8'h40, mem[40]=AA, while a word is pending → `Valida`=0 for one cycle, then `InstrucaoSaida`=AA, `PcSaida`=40.
- mem[05]=FF → FF delivered at `PcSaida`=05; `Parado`=1; `Endereco` stays 05; `Valida`=0 after transfer. Then `Desvio` to 10 → fetch resumes at 10 and `Parado`=0.
- `AlvoDesvio`=FE, mem[FE]=11, mem[FF]=22, mem[00]=33 → PCs FE, FF, 00 delivered; `Volta`=1 for exactly one cycle at the wrap.
- `Reset` asserted mid-stream during a stall → next cycle `Valida`=0, `Endereco`=00, `Parado`=0. First word after release is mem[00].

Source files
------------

// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch stage and the decoder that
// consumes its output: state encoding, default width and the halt word.
package unidade_busca_pkg;

    // Fetch state: BUSCA fetches normally, PARADO is halted until a redirect.
    typedef enum logic {
        BUSCA  = 1'b0,
        PARADO = 1'b1
    } estado_t;

    // Default address / instruction width.
    localparam int LARGURA_PADRAO = 8;

    // Halt word. The decoder recognises the same encoding.
    localparam logic [LARGURA_PADRAO-1:0] PALAVRA_PARADA_PADRAO = 8'hFF;

    // True when a fetched word is the halt encoding.
    function automatic logic eh_palavra_parada(
        input logic [LARGURA_PADRAO-1:0] palavra,
        input logic [LARGURA_PADRAO-1:0] parada
    );
        return palavra == parada;
    endfunction

endpackage

// File: rtl/unidade_busca_contador_programa.sv
// Program counter register: reset-to-initial, load (redirect), increment or
// hold. Flags a one-cycle wrap pulse when an increment rolls over to zero.
module contador_programa
    import unidade_busca_pkg::*;
#(
    parameter int                 LARGURA    = LARGURA_PADRAO,
    parameter logic [LARGURA-1:0] PC_INICIAL = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               carregar_i,
    input  logic               incrementar_i,
    input  logic [LARGURA-1:0] alvo_i,
    output logic [LARGURA-1:0] pc_o,
    output logic               volta_o
);

    logic [LARGURA-1:0] pc_q;
    logic [LARGURA-1:0] pc_d;
    logic               volta_q;
    logic               volta_d;

    // Next PC: load has priority over increment; otherwise hold.
    always_comb begin
        pc_d    = pc_q;
        volta_d = 1'b0;
        if (carregar_i) begin
            pc_d = alvo_i;
        end else if (incrementar_i) begin
            pc_d    = pc_q + 1'b1;
            volta_d = (pc_q == {LARGURA{1'b1}});
        end
    end

    // PC and wrap flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= PC_INICIAL;
            volta_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            volta_q <= volta_d;
        end
    end

    assign pc_o    = pc_q;
    assign volta_o = volta_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch stage: drives the PC to the instruction memory, captures
// the returned word into an output register and hands it to the decoder
// through a valid/ready handshake, with stall, redirect and halt handling.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int                 LARGURA        = LARGURA_PADRAO,
    parameter logic [LARGURA-1:0] PC_INICIAL     = 8'h00,
    parameter logic [LARGURA-1:0] PALAVRA_PARADA = PALAVRA_PARADA_PADRAO
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [LARGURA-1:0] Endereco,
    input  logic [LARGURA-1:0] Instrucao,
    input  logic               Desvio,
    input  logic [LARGURA-1:0] AlvoDesvio,
    input  logic               Pronto,
    output logic               Valida,
    output logic [LARGURA-1:0] InstrucaoSaida,
    output logic [LARGURA-1:0] PcSaida,
    output logic               Parado,
    output logic               Volta
);

    estado_t            estado_q;
    logic               valida_q;
    logic [LARGURA-1:0] instrucao_q;
    logic [LARGURA-1:0] pc_saida_q;
    logic [LARGURA-1:0] pc;
    logic               transferencia;
    logic               captura;
    logic               eh_parada;
    logic               incrementar;

    // The decoder takes the held word when both sides agree this cycle.
    assign transferencia = valida_q && Pronto;
    // A new word may enter the output register only while fetching, with no
    // redirect pending, and when the register is empty or being drained.
    assign captura       = (estado_q == BUSCA) && !Desvio && (!valida_q || transferencia);
    assign eh_parada     = (Instrucao == PALAVRA_PARADA);
    // The halt word is delivered but the PC stays on it.
    assign incrementar   = captura && !eh_parada;

    contador_programa #(
        .LARGURA    (LARGURA),
        .PC_INICIAL (PC_INICIAL)
    ) u_contador_programa (
        .clk_i         (Clock),
        .rst_i         (Reset),
        .carregar_i    (Desvio),
        .incrementar_i (incrementar),
        .alvo_i        (AlvoDesvio),
        .pc_o          (pc),
        .volta_o       (Volta)
    );

    // Fetch state machine and output register; redirect overrides everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q    <= BUSCA;
            valida_q    <= 1'b0;
            instrucao_q <= '0;
            pc_saida_q  <= '0;
        end else if (Desvio) begin
            estado_q <= BUSCA;
            valida_q <= 1'b0;
        end else if (captura) begin
            instrucao_q <= Instrucao;
            pc_saida_q  <= pc;
            valida_q    <= 1'b1;
            if (eh_parada) begin
                estado_q <= PARADO;
            end
        end else if (transferencia) begin
            valida_q <= 1'b0;
        end
    end

    assign Endereco       = pc;
    assign Valida         = valida_q;
    assign InstrucaoSaida = instrucao_q;
    assign PcSaida        = pc_saida_q;
    assign Parado         = (estado_q == PARADO);

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for the fetch stage: instruction memory model, behavioural reference
// model, per-cycle comparison and directed plus random stimulus.
module tb_unidade_busca;

    localparam int W = 8;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] Endereco;
    logic [W-1:0] Instrucao;
    logic         Desvio;
    logic [W-1:0] AlvoDesvio;
    logic         Pronto;
    logic         Valida;
    logic [W-1:0] InstrucaoSaida;
    logic [W-1:0] PcSaida;
    logic         Parado;
    logic         Volta;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem [0:255];

    unidade_busca dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Endereco       (Endereco),
        .Instrucao      (Instrucao),
        .Desvio         (Desvio),
        .AlvoDesvio     (AlvoDesvio),
        .Pronto         (Pronto),
        .Valida         (Valida),
        .InstrucaoSaida (InstrucaoSaida),
        .PcSaida        (PcSaida),
        .Parado         (Parado),
        .Volta          (Volta)
    );

    always #5 Clock = ~Clock;

    // Instruction memory: asynchronous-style read refreshed on the falling edge.
    always @(negedge Clock) Instrucao <= mem[Endereco];

    // Reference model state (what the outputs must be after each rising edge).
    logic [W-1:0] m_pc     = 8'h00;
    logic         m_valida = 1'b0;
    logic [W-1:0] m_instr  = 8'h00;
    logic [W-1:0] m_pcs    = 8'h00;
    logic         m_parado = 1'b0;
    logic         m_volta  = 1'b0;
    bit           ativo    = 1'b0;

    always @(posedge Clock) begin
        logic         xfer;
        logic [W-1:0] palavra;
        if (Reset) begin
            m_pc = 8'h00; m_valida = 0; m_instr = 0; m_pcs = 0; m_parado = 0; m_volta = 0;
        end else begin
            xfer    = m_valida && Pronto;
            m_volta = 0;
            if (Desvio) begin
                m_pc = AlvoDesvio; m_valida = 0; m_parado = 0;
            end else if (!m_parado && (!m_valida || xfer)) begin
                palavra  = mem[m_pc];
                m_instr  = palavra;
                m_pcs    = m_pc;
                m_valida = 1;
                if (palavra == 8'hFF) m_parado = 1;
                else begin
                    m_volta = (m_pc == 8'hFF);
                    m_pc    = m_pc + 8'd1;
                end
            end else if (xfer) begin
                m_valida = 0;
            end
        end
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nome, got, exp, $time);
        end
    endtask

    // Every cycle, compare all outputs against the model.
    always @(posedge Clock) begin
        #1;
        if (ativo) begin
            chk("m_valida",   {31'd0, Valida},   {31'd0, m_valida});
            chk("m_endereco", {24'd0, Endereco}, {24'd0, m_pc});
            chk("m_parado",   {31'd0, Parado},   {31'd0, m_parado});
            chk("m_volta",    {31'd0, Volta},    {31'd0, m_volta});
            chk("m_instr",    {24'd0, InstrucaoSaida}, {24'd0, m_instr});
            chk("m_pcsaida",  {24'd0, PcSaida},  {24'd0, m_pcs});
        end
    end

    task automatic ciclo();
        @(posedge Clock);
        #1;
    endtask

    task automatic saida(input string nome, input logic [W-1:0] pc_exp, input logic [W-1:0] ins_exp);
        chk({nome, "_valida"}, {31'd0, Valida}, 32'd1);
        chk({nome, "_pc"},     {24'd0, PcSaida}, {24'd0, pc_exp});
        chk({nome, "_instr"},  {24'd0, InstrucaoSaida}, {24'd0, ins_exp});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] v;
            v = W'($urandom_range(0, 254));
            mem[i] = v;
        end
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        mem[4] = 8'h05; mem[5] = 8'hFF;
        mem[8'h40] = 8'hAA; mem[8'h10] = 8'h5A;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;

        Reset = 1; Pronto = 1; Desvio = 0; AlvoDesvio = 0;
        ativo = 1;
        ciclo();
        chk("rst_valida", {31'd0, Valida}, 32'd0);
        chk("rst_instr",  {24'd0, InstrucaoSaida}, 32'd0);
        chk("rst_pcsaida", {24'd0, PcSaida}, 32'd0);
        chk("rst_parado", {31'd0, Parado}, 32'd0);
        chk("rst_volta",  {31'd0, Volta}, 32'd0);
        chk("rst_end",    {24'd0, Endereco}, 32'd0);
        ciclo();
        Reset = 0;

        // Streaming after reset release.
        ciclo(); saida("seq0", 8'h00, 8'h01);
        ciclo(); saida("seq1", 8'h01, 8'h02);

        // Stall for three cycles.
        Pronto = 0;
        for (int i = 0; i < 3; i++) begin
            ciclo();
            saida("stall", 8'h01, 8'h02);
            chk("stall_end", {24'd0, Endereco}, 32'h02);
        end
        Pronto = 1;
        ciclo(); saida("resume", 8'h02, 8'h03);
        ciclo(); saida("seq3", 8'h03, 8'h04);

        // Redirect while a word is pending.
        Pronto = 0; Desvio = 1; AlvoDesvio = 8'h40;
        ciclo(); chk("desvio_bolha", {31'd0, Valida}, 32'd0);
        Desvio = 0; Pronto = 1;
        ciclo(); saida("desvio_alvo", 8'h40, 8'hAA);

        // Halt word at address 05.
        Desvio = 1; AlvoDesvio = 8'h04;
        ciclo();
        Desvio = 0;
        ciclo(); saida("pre_halt", 8'h04, 8'h05);
        ciclo(); saida("halt", 8'h05, 8'hFF);
        chk("halt_parado", {31'd0, Parado}, 32'd1);
        chk("halt_end", {24'd0, Endereco}, 32'h05);
        ciclo();
        chk("halt_drop", {31'd0, Valida}, 32'd0);
        chk("halt_end2", {24'd0, Endereco}, 32'h05);
        chk("halt_parado2", {31'd0, Parado}, 32'd1);
        ciclo();
        chk("halt_end3", {24'd0, Endereco}, 32'h05);
        Desvio = 1; AlvoDesvio = 8'h10;
        ciclo(); chk("sai_parado", {31'd0, Parado}, 32'd0);
        Desvio = 0;
        ciclo(); saida("retoma", 8'h10, 8'h5A);

        // Wrap from FF to 00.
        mem[0] = 8'h33;
        Desvio = 1; AlvoDesvio = 8'hFE;
        ciclo();
        Desvio = 0;
        ciclo(); saida("wrapFE", 8'hFE, 8'h11); chk("volta_FE", {31'd0, Volta}, 32'd0);
        ciclo(); saida("wrapFF", 8'hFF, 8'h22); chk("volta_FF", {31'd0, Volta}, 32'd1);
        ciclo(); saida("wrap00", 8'h00, 8'h33); chk("volta_00", {31'd0, Volta}, 32'd0);

        // Reset during a stall.
        Pronto = 0;
        ciclo();
        Reset = 1;
        ciclo();
        chk("rst_mid_valida", {31'd0, Valida}, 32'd0);
        chk("rst_mid_end", {24'd0, Endereco}, 32'd0);
        chk("rst_mid_parado", {31'd0, Parado}, 32'd0);
        Reset = 0; Pronto = 1;
        ciclo(); saida("pos_rst", 8'h00, 8'h33);

        // Random traffic; the per-cycle compare process checks every cycle.
        for (int n = 0; n < 600; n++) begin
            Pronto     = ($urandom_range(0, 9) < 7);
            Desvio     = ($urandom_range(0, 9) == 0);
            AlvoDesvio = ($urandom_range(0, 3) == 0) ? 8'hFD + W'($urandom_range(0, 2))
                                                     : W'($urandom_range(0, 255));
            Reset      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                int a;
                a = $urandom_range(0, 255);
                mem[a] = ($urandom_range(0, 15) == 0) ? 8'hFF : W'($urandom_range(0, 254));
            end
            ciclo();
        end
        Reset = 0; Desvio = 0; Pronto = 1;
        ciclo();
        ativo = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
